// File: rtl/io.sv
// io: switch/button front end for an 8-bit ALU whose registered result drives the LEDs.
// Define IO_DEBOUNCE_EN to insert a per-button debouncer ahead of the edge detectors.
module io #(
    parameter int DATA_LENGTH     = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_A,
    input  logic                   btn_B,
    input  logic                   btn_Op,
    input  logic [DATA_LENGTH-1:0] switches,
    output logic [DATA_LENGTH-1:0] Leds
);
    logic [2:0]             btn, b1, b2, lvl, prev, edge_r;
    logic [DATA_LENGTH-1:0] sw1, sw2, a, b, result;
    logic [5:0]             op;

    assign btn = {btn_Op, btn_B, btn_A};

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [CW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt    <= '0;
                lvl[i] <= 1'b0;
            end else if (b2[i] == lvl[i]) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                lvl[i] <= b2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign lvl = b2;
`endif

    // edge_r is registered, so loads land one cycle after the rising edge is seen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw1    <= '0;
            sw2    <= '0;
            b1     <= '0;
            b2     <= '0;
            prev   <= '0;
            edge_r <= '0;
            a      <= '0;
            b      <= '0;
            op     <= '0;
            Leds   <= '0;
        end else begin
            sw1    <= switches;
            sw2    <= sw1;
            b1     <= btn;
            b2     <= b1;
            prev   <= lvl;
            edge_r <= lvl & ~prev;
            if (edge_r[0]) a <= sw2;
            if (edge_r[1]) b <= sw2;
            if (edge_r[2]) op <= sw2[5:0];
            Leds   <= result;
        end
    end

    always_comb begin
        result = '0;
        case (op)
            6'h20: result = a + b;
            6'h22: result = a - b;
            6'h24: result = a & b;
            6'h25: result = a | b;
            6'h26: result = a ^ b;
            6'h27: result = ~(a | b);
            6'h02: result = $signed(a) >>> b;
            6'h03: result = a >> b;
            default: result = '0;
        endcase
    end
endmodule

// File: tb/tb_io.sv
// tb_io: randomized self-checking bench for io against a behavioural ALU/press model.
module tb_io;
    localparam int D = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int HOLD = D + 2;
    localparam int SETTLE = 8 + 2 * D;
    localparam int LAT = 4 + D;
`else
    localparam int HOLD = 2;
    localparam int SETTLE = 8;
    localparam int LAT = 4;
`endif

    logic       clk = 0;
    logic       rst_n = 0;
    logic       btn_A = 0, btn_B = 0, btn_Op = 0;
    logic [7:0] switches = 0;
    logic [7:0] Leds;
    logic [7:0] ma = 0, mb = 0;
    logic [5:0] mop = 0;
    int         compared = 0;
    int         mismatched = 0;

    io #(.DATA_LENGTH(8), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .btn_A(btn_A), .btn_B(btn_B),
        .btn_Op(btn_Op), .switches(switches), .Leds(Leds)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y, input logic [5:0] o);
        int sx, r;
        sx = x[7] ? int'(x) - 256 : int'(x);
        case (o)
            6'h20: r = (int'(x) + int'(y)) % 256;
            6'h22: r = (int'(x) - int'(y) + 256) % 256;
            6'h24: r = int'(x & y);
            6'h25: r = int'(x | y);
            6'h26: r = int'(x ^ y);
            6'h27: r = 255 - int'(x | y);
            6'h02: r = (y >= 8) ? (sx < 0 ? 255 : 0) : ((sx >>> y) & 255);
            6'h03: r = (y >= 8) ? 0 : int'(x) / (1 << y);
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m, input logic [7:0] v);
        switches = v;
        cyc(3);
        {btn_Op, btn_B, btn_A} = m;
        cyc(HOLD);
        {btn_Op, btn_B, btn_A} = 3'b000;
        cyc(SETTLE);
        if (m[0]) ma = v;
        if (m[1]) mb = v;
        if (m[2]) mop = v[5:0];
    endtask

    task automatic test_reset;
        cyc(2);
        compared++;
        if (Leds !== 8'h00) begin mismatched++; $display("FAIL reset_init: Leds=%h want 00", Leds); end
        rst_n = 1;
        press(3'b001, 8'h05); press(3'b010, 8'h03); press(3'b100, 8'h20);
        rst_n = 0;
        cyc(2);
        ma = 0; mb = 0; mop = 0;
        compared++;
        if (Leds !== 8'h00) begin mismatched++; $display("FAIL reset_after_use: Leds=%h want 00", Leds); end
        rst_n = 1;
        press(3'b100, 8'h20);
        compared++;
        if (Leds !== 8'h00) begin mismatched++; $display("FAIL reset_op_only: Leds=%h want 00", Leds); end
        switches = 8'h5A;
        cyc(3);
        btn_A = 1;
        cyc(1);
        rst_n = 0;
        cyc(2);
        btn_A = 0;
        rst_n = 1;
        cyc(SETTLE);
        press(3'b100, 8'h25);
        compared++;
        if (Leds !== 8'h00) begin mismatched++; $display("FAIL reset_mid_entry: Leds=%h want 00", Leds); end
    endtask

    task automatic test_arith;
        logic [7:0] t [4][4] = '{'{8'h05, 8'h03, 8'h20, 8'h08}, '{8'h05, 8'h03, 8'h22, 8'h02},
                                 '{8'h7F, 8'h01, 8'h20, 8'h80}, '{8'h00, 8'h01, 8'h22, 8'hFF}};
        for (int i = 0; i < 4; i++) begin
            press(3'b001, t[i][0]); press(3'b010, t[i][1]); press(3'b100, t[i][2]);
            compared++;
            if (Leds !== t[i][3]) begin mismatched++; $display("FAIL arith_%0d: Leds=%h want %h", i, Leds, t[i][3]); end
        end
    endtask

    task automatic test_logic;
        logic [7:0] ops [4] = '{8'h24, 8'h25, 8'h26, 8'h27};
        logic [7:0] exp [4] = '{8'h88, 8'hEE, 8'h66, 8'h11};
        press(3'b001, 8'hCC); press(3'b010, 8'hAA);
        for (int i = 0; i < 4; i++) begin
            press(3'b100, ops[i]);
            compared++;
            if (Leds !== exp[i]) begin mismatched++; $display("FAIL logic_%h: Leds=%h want %h", ops[i], Leds, exp[i]); end
        end
    endtask

    task automatic test_shift;
        logic [7:0] bs [4]  = '{8'h02, 8'h02, 8'h09, 8'h09};
        logic [7:0] ops [4] = '{8'h02, 8'h03, 8'h02, 8'h03};
        logic [7:0] exp [4] = '{8'hE0, 8'h20, 8'hFF, 8'h00};
        press(3'b001, 8'h80);
        for (int i = 0; i < 4; i++) begin
            press(3'b010, bs[i]); press(3'b100, ops[i]);
            compared++;
            if (Leds !== exp[i]) begin mismatched++; $display("FAIL shift_%0d: Leds=%h want %h", i, Leds, exp[i]); end
        end
    endtask

    task automatic test_hold;
        press(3'b010, 8'h00); press(3'b100, 8'h20);
        switches = 8'h11;
        cyc(3);
        btn_A = 1;
        cyc(8);
        switches = 8'h22;
        cyc(12);
        btn_A = 0;
        cyc(SETTLE);
        compared++;
        if (Leds !== 8'h11) begin mismatched++; $display("FAIL hold: Leds=%h want 11", Leds); end
        ma = 8'h11;
    endtask

    task automatic test_back_to_back;
        press(3'b011, 8'h33);
        compared++;
        if (Leds !== 8'h66) begin mismatched++; $display("FAIL simultaneous: Leds=%h want 66", Leds); end
        press(3'b100, 8'h21);
        compared++;
        if (Leds !== 8'h00) begin mismatched++; $display("FAIL bad_op: Leds=%h want 00", Leds); end
    endtask

    task automatic test_latency;
        int n = 0;
        logic [7:0] old;
        press(3'b001, 8'h01); press(3'b010, 8'h01); press(3'b100, 8'h20);
        old = Leds;
        switches = 8'h10;
        cyc(3);
        btn_A = 1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (Leds !== old) break;
        end
        compared++;
        if (n - 1 != LAT) begin mismatched++; $display("FAIL latency: cycles=%0d want %0d", n - 1, LAT); end
        @(negedge clk);
        btn_A = 0;
        cyc(SETTLE);
        ma = 8'h10;
    endtask

`ifdef IO_DEBOUNCE_EN
    task automatic test_glitch;
        switches = 8'h44;
        cyc(3);
        btn_A = 1;
        cyc(D - 1);
        btn_A = 0;
        cyc(SETTLE);
        compared++;
        if (Leds !== model(ma, mb, mop)) begin mismatched++; $display("FAIL glitch_short: Leds=%h want %h", Leds, model(ma, mb, mop)); end
        btn_A = 1;
        cyc(D + 2);
        btn_A = 0;
        cyc(SETTLE);
        ma = 8'h44;
        compared++;
        if (Leds !== model(ma, mb, mop)) begin mismatched++; $display("FAIL glitch_long: Leds=%h want %h", Leds, model(ma, mb, mop)); end
    endtask
`endif

    task automatic test_random;
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        for (int i = 0; i < 24; i++) begin
            press(3'b001, 8'($urandom));
            press(3'b010, (i % 3 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom));
            press(3'b100, (i % 5 == 4) ? 8'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)]);
            compared++;
            if (Leds !== model(ma, mb, mop))
                begin mismatched++; $display("FAIL random_%0d: A=%h B=%h Op=%h Leds=%h want %h", i, ma, mb, mop, Leds, model(ma, mb, mop)); end
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_logic;
        test_shift;
        test_hold;
        test_back_to_back;
        test_latency;
`ifdef IO_DEBOUNCE_EN
        test_glitch;
`endif
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
